// File: rtl/serial_parity_checker_pkg.sv
// Shared constants for the serial parity receiver: FSM state encoding and parity sense.
package serial_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/serial_parity_checker_parity_acc.sv
// One-bit XOR accumulator: folds d into q when en is set, clr zeroes it.
module parity_acc (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);
    logic acc_q;
    logic d_gated;
    logic acc_d;

    assign d_gated = en & d;
    xor u_xor (acc_d, acc_q, d_gated);

    always_ff @(posedge clk) begin
        if (reset)    acc_q <= 1'b0;
        else if (clr) acc_q <= 1'b0;
        else          acc_q <= acc_d;
    end

    assign q = acc_q;
endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises LSB-first frames of DATA_BITS data bits plus one parity bit and
// reports the word with a parity-error flag as a single-cycle result.
module serial_parity_checker
    import serial_pkg::*;
#(
    parameter int   DATA_BITS = 8,
    parameter logic ODD       = PAR_EVEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic                 in_bit,
    output logic                 busy,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 parity_err
);
    localparam int         CW       = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST  = CW'(DATA_BITS - 1);
    localparam logic [1:0] ST_FIRST = (DATA_BITS == 1) ? ST_PARITY : ST_DATA;

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] sreg_q, sreg_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 err_q, vld_q;
    logic                 acc_q, acc_clr, acc_en;
    logic                 take_data, take_par, st_bad;

    assign st_bad    = (state_q == 2'd3);
    assign take_data = in_valid && !clear && (state_q == ST_IDLE || state_q == ST_DATA);
    assign take_par  = in_valid && !clear && (state_q == ST_PARITY);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (in_valid) state_d = ST_FIRST;
                ST_DATA:   if (in_valid && cnt_q == LAST) state_d = ST_PARITY;
                ST_PARITY: if (in_valid) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // Counter and shift register; cnt_q addresses the slot for the incoming bit.
    always_comb begin
        cnt_d  = cnt_q;
        sreg_d = sreg_q;
        if (clear) begin
            cnt_d  = '0;
            sreg_d = '0;
        end else if (take_par || st_bad) begin
            cnt_d = '0;
        end else if (take_data) begin
            for (int i = 0; i < DATA_BITS; i++)
                if (cnt_q == CW'(i)) sreg_d[i] = in_bit;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            sreg_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sreg_q <= sreg_d;
        end
    end

    // Accumulator is emptied when a frame completes so IDLE always starts from 0.
    assign acc_clr = clear || (in_valid && state_q == ST_PARITY) || st_bad;
    assign acc_en  = take_data;

    parity_acc u_acc (
        .clk   (clk),
        .reset (reset),
        .clr   (acc_clr),
        .en    (acc_en),
        .d     (in_bit),
        .q     (acc_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            vld_q <= take_par;
            if (take_par) begin
                data_q <= sreg_q;
                err_q  <= acc_q ^ in_bit ^ ODD;
            end
        end
    end

    assign out_valid  = vld_q;
    assign out_data   = data_q;
    assign parity_err = err_q;
endmodule
